fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: three-way arbiter (video scanout, blitter, CPU) in front
// of a single-port framebuffer RAM. Grants are combinational; the RAM port is
// registered one cycle after the grant, and read data returns one cycle later.
// Optional feature macro: FB_ARB_ROUND_ROBIN_EN (blitter/CPU alternate on ties;
// when undefined the blitter always wins over the CPU).
module fb_port_arbiter #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_req,
    input  logic [8:0]  vid_addr,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    input  logic        blt_req,
    input  logic [8:0]  blt_addr,
    input  logic [15:0] blt_wdata,
    input  logic        blt_we,
    input  logic        blt_lock,
    output logic        blt_gnt,
    output logic        blt_rvalid,
    input  logic        cpu_req,
    input  logic [8:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] rdata,
    output logic [8:0]  buf_addr,
    output logic [15:0] buf_in,
    output logic        buf_enable,
    output logic        buf_write,
    input  logic [15:0] buf_out,
    output logic        lock_active
);

    typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_t;

    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    lock_state_t lock_state_q, lock_state_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [2:0]  rd_pend_q;     // {vid, blt, cpu} reads issued to the RAM this cycle
    logic        cpu_eligible;

    assign lock_active  = (lock_state_q == LK_LOCKED);
    assign rdata        = buf_out;
    assign cpu_eligible = cpu_req & ~lock_active;

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic rr_blt_pref_q;        // 1: blitter wins the next blitter/CPU tie

    // Grant selection: video first, then blitter/CPU by round-robin pointer.
    always_comb begin
        vid_gnt = rst_n & vid_req;
        blt_gnt = rst_n & ~vid_req & blt_req & (~cpu_eligible | rr_blt_pref_q);
        cpu_gnt = rst_n & ~vid_req & cpu_eligible & (~blt_req | ~rr_blt_pref_q);
    end

    // Round-robin pointer: whichever of blitter/CPU was just served loses the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_blt_pref_q <= 1'b1;
        end else if (blt_gnt) begin
            rr_blt_pref_q <= 1'b0;
        end else if (cpu_gnt) begin
            rr_blt_pref_q <= 1'b1;
        end
    end
`else
    // Grant selection: video first, then blitter, then CPU (blocked while locked).
    always_comb begin
        vid_gnt = rst_n & vid_req;
        blt_gnt = rst_n & ~vid_req & blt_req;
        cpu_gnt = rst_n & ~vid_req & cpu_eligible & ~blt_req;
    end
`endif

    // Lock state register and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state_q <= LK_IDLE;
            lock_cnt_q   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            lock_state_q <= lock_state_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    // Lock next-state: acquire on a locking blitter grant; release on an
    // unlocking grant, on the blitter withdrawing, or after LOCK_MAX idle cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        lock_state_d = lock_state_q;
        lock_cnt_d   = lock_cnt_q;
        unique case (lock_state_q)
            LK_IDLE: begin
                if (blt_gnt && blt_lock) begin
                    lock_state_d = LK_LOCKED;
                    lock_cnt_d   = 4'd0;
                end
            end
            LK_LOCKED: begin
                if (blt_gnt) begin
                    lock_cnt_d = 4'd0;
                    if (!blt_lock) lock_state_d = LK_IDLE;
                end else if (!blt_req && !blt_lock) begin
                    lock_state_d = LK_IDLE;
                    lock_cnt_d   = 4'd0;
                end else if (lock_cnt_q + 4'd1 == LOCK_MAX_C) begin
                    lock_state_d = LK_IDLE;
                    lock_cnt_d   = 4'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
            end
            default: begin
                lock_state_d = LK_IDLE;
                lock_cnt_d   = 4'd0;
            end
        endcase
    end

    // RAM port register and two-stage read-valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register here is a small control/datapath flop, so all of them get a reset value; in-flight reads are discarded.
            buf_enable <= 1'b0;
            buf_write  <= 1'b0;
            buf_addr   <= 9'd0;
            buf_in     <= 16'd0;
            rd_pend_q  <= 3'b000;
            vid_rvalid <= 1'b0;
            blt_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            buf_enable <= vid_gnt | blt_gnt | cpu_gnt;
            buf_write  <= (blt_gnt & blt_we) | (cpu_gnt & cpu_we);
            if (vid_gnt) begin
                buf_addr <= vid_addr;
            end else if (blt_gnt) begin
                buf_addr <= blt_addr;
                buf_in   <= blt_wdata;
            end else if (cpu_gnt) begin
                buf_addr <= cpu_addr;
                buf_in   <= cpu_wdata;
            end
            rd_pend_q  <= {vid_gnt, blt_gnt & ~blt_we, cpu_gnt & ~cpu_we};
            vid_rvalid <= rd_pend_q[2];
            blt_rvalid <= rd_pend_q[1];
            cpu_rvalid <= rd_pend_q[0];
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: inputs change 1 ns after the rising
// edge, outputs are sampled on the falling edge of the same cycle.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vid_req;
    logic [8:0]  vid_addr;
    logic        vid_gnt, vid_rvalid;
    logic        blt_req;
    logic [8:0]  blt_addr;
    logic [15:0] blt_wdata;
    logic        blt_we, blt_lock;
    logic        blt_gnt, blt_rvalid;
    logic        cpu_req;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] rdata;
    logic [8:0]  buf_addr;
    logic [15:0] buf_in;
    logic        buf_enable, buf_write;
    logic [15:0] buf_out;
    logic        lock_active;

    int checks   = 0;
    int failures = 0;

    fb_port_arbiter #(.LOCK_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
        .blt_req(blt_req), .blt_addr(blt_addr), .blt_wdata(blt_wdata), .blt_we(blt_we),
        .blt_lock(blt_lock), .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .rdata(rdata), .buf_addr(buf_addr), .buf_in(buf_in), .buf_enable(buf_enable),
        .buf_write(buf_write), .buf_out(buf_out), .lock_active(lock_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        vid_req = 0; vid_addr = '0;
        blt_req = 0; blt_addr = '0; blt_wdata = '0; blt_we = 0; blt_lock = 0;
        cpu_req = 0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic exp_blt_tie [4];

    initial begin
`ifdef FB_ARB_ROUND_ROBIN_EN
        exp_blt_tie = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_blt_tie = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        rst_n   = 0;
        buf_out = 16'hBEEF;
        idle_inputs();
        vid_req = 1;
        #3;
        check("rst_vid_gnt", vid_gnt, 0);
        check("rst_buf_enable", buf_enable, 0);
        check("rst_buf_write", buf_write, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_buf_in", buf_in, 0);
        check("rst_lock", lock_active, 0);
        check("rst_rvalids", {vid_rvalid, blt_rvalid, cpu_rvalid}, 0);
        next_cycle();
        next_cycle();
        rst_n = 1;

        // All three request: video wins, read returns two cycles later.
        vid_req = 1; vid_addr = 9'h1A3;
        blt_req = 1; blt_addr = 9'h005;
        cpu_req = 1; cpu_addr = 9'h007;
        @(negedge clk);
        check("all_vid_gnt", vid_gnt, 1);
        check("all_blt_gnt", blt_gnt, 0);
        check("all_cpu_gnt", cpu_gnt, 0);
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("vid_n1_en", buf_enable, 1);
        check("vid_n1_addr", buf_addr, 9'h1A3);
        check("vid_n1_we", buf_write, 0);
        check("vid_n1_rv", vid_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("vid_n2_rv", vid_rvalid, 1);
        check("vid_n2_rdata", rdata, 16'hBEEF);
        check("vid_n2_en", buf_enable, 0);
        next_cycle();
        @(negedge clk);
        check("vid_n3_rv", vid_rvalid, 0);

        // Blitter write: RAM port carries the write, no read valid.
        blt_req = 1; blt_we = 1; blt_addr = 9'h005; blt_wdata = 16'hA5A5;
        @(negedge clk);
        check("bw_gnt", blt_gnt, 1);
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("bw_en", buf_enable, 1);
        check("bw_we", buf_write, 1);
        check("bw_addr", buf_addr, 9'h005);
        check("bw_data", buf_in, 16'hA5A5);
        next_cycle();
        @(negedge clk);
        check("bw_rv", blt_rvalid, 0);
        check("bw_hold_addr", buf_addr, 9'h005);
        check("bw_idle_we", buf_write, 0);

        // Back-to-back reads: blitter then CPU.
        blt_req = 1; blt_addr = 9'h010;
        @(negedge clk);
        check("b2b_blt_gnt", blt_gnt, 1);
        next_cycle(); idle_inputs();
        cpu_req = 1; cpu_addr = 9'h011;
        @(negedge clk);
        check("b2b_cpu_gnt", cpu_gnt, 1);
        check("b2b_addr0", buf_addr, 9'h010);
        next_cycle(); idle_inputs();
        @(negedge clk);
        check("b2b_blt_rv", {blt_rvalid, cpu_rvalid}, 2'b10);
        check("b2b_addr1", buf_addr, 9'h011);
        next_cycle();
        @(negedge clk);
        check("b2b_cpu_rv", {blt_rvalid, cpu_rvalid}, 2'b01);

        // Reset one cycle after a read grant: the read is dropped.
        next_cycle();
        cpu_req = 1; cpu_addr = 9'h033;
        @(negedge clk);
        check("rr_cpu_gnt", cpu_gnt, 1);
        next_cycle(); idle_inputs();
        check("rr_en_before", buf_enable, 1);
        #1 rst_n = 0;
        #1;
        check("rr_en_now", buf_enable, 0);
        check("rr_addr_now", buf_addr, 0);
        next_cycle();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rr_no_rv%0d", i), {vid_rvalid, blt_rvalid, cpu_rvalid}, 0);
            next_cycle();
        end

        // Blitter/CPU tie for four cycles, no lock.
        blt_req = 1; cpu_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("tie_blt%0d", i), blt_gnt, exp_blt_tie[i]);
            check($sformatf("tie_cpu%0d", i), cpu_gnt, !exp_blt_tie[i]);
            next_cycle();
        end
        idle_inputs();

        // Lock timeout: CPU starved for LOCK_MAX cycles, granted the cycle after release.
        blt_req = 1; blt_lock = 1; blt_we = 1; cpu_req = 1; cpu_we = 1;
        @(negedge clk);
        check("lk_gnt", blt_gnt, 1);
        check("lk_pre", lock_active, 0);
        next_cycle();
        blt_req = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("lk_held%0d", i), lock_active, 1);
            check($sformatf("lk_cpu_blk%0d", i), cpu_gnt, 0);
            next_cycle();
        end
        @(negedge clk);
        check("lk_released", lock_active, 0);
        check("lk_cpu_gnt", cpu_gnt, 1);
        next_cycle(); idle_inputs();

        // Lock: video overrides, then explicit unlock, CPU follows next cycle.
        blt_req = 1; blt_lock = 1;
        @(negedge clk);
        check("lk2_gnt", blt_gnt, 1);
        next_cycle();
        vid_req = 1; cpu_req = 1;
        @(negedge clk);
        check("lk2_vid", {vid_gnt, blt_gnt, cpu_gnt}, 3'b100);
        check("lk2_active", lock_active, 1);
        next_cycle();
        vid_req = 0; blt_lock = 0;
        @(negedge clk);
        check("lk2_unlock", {vid_gnt, blt_gnt, cpu_gnt}, 3'b010);
        check("lk2_still", lock_active, 1);
        next_cycle();
        blt_req = 0;
        @(negedge clk);
        check("lk2_fall", lock_active, 0);
        check("lk2_cpu", cpu_gnt, 1);
        next_cycle(); idle_inputs();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
